// File: rtl/axi_slave_package.sv
// Shared types for the AXI slave bridge completion path: completion kinds,
// B/R FIFO entry layouts, AXI response codes and the beats-from-length helper.
package axi_slave_package;

  localparam int AXI_DATA_WIDTH = 1024;
  localparam int AXI_ID_WIDTH   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    CPL_NONE = 2'd0,
    CPL_WR   = 2'd1,
    CPL_RD   = 2'd2
  } cpl_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_R_PUSH = 1'b1
  } push_state_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    logic [1:0]              resp;
  } b_entry_t;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [1:0]                resp;
    logic                      last;
  } r_entry_t;

  // A length field of 0 stands for a full 1024-DW completion.
  function automatic logic [10:0] cpl_beats(input logic [9:0] len, input int dw_per_beat);
    logic [10:0] l;
    l = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    return 11'((int'(l) + dw_per_beat - 1) / dw_per_beat);
  endfunction

endpackage

// File: rtl/p2a_push_fsm_if.sv
// P2A mapper to Push FSM link: decoded completion in, grant/command back.
// Handshake: P2A holds Type/Length/Data stable until Grant is seen high at a rising edge.
interface P2A_Push_FSM_Interface
  import axi_slave_package::*;
#(
  parameter int DATA_WIDTH = AXI_DATA_WIDTH
);
  cpl_t                  Cpl_Type;
  logic [9:0]            Cpl_Length;
  logic [DATA_WIDTH-1:0] Cpl_Data;
  logic                  Cpl_Grant;
  logic                  Cpl_Command;

  modport FSM_P2A (
    input  Cpl_Type,
    input  Cpl_Length,
    input  Cpl_Data,
    output Cpl_Grant,
    output Cpl_Command
  );

  modport P2A (
    output Cpl_Type,
    output Cpl_Length,
    output Cpl_Data,
    input  Cpl_Grant,
    input  Cpl_Command
  );
endinterface

// File: rtl/axi_slave_push_fsm.sv
// Push FSM: turns decoded PCIe completions into B-channel responses and
// DATA_WIDTH-wide R-channel beats, one completion in flight at a time.
module axi_slave_push_fsm
  import axi_slave_package::*;
#(
  parameter  int DATA_WIDTH  = AXI_DATA_WIDTH,
  parameter  int ID_WIDTH    = AXI_ID_WIDTH,
  localparam int DW_PER_BEAT = DATA_WIDTH / 32
)(
  input  logic                ACLK,
  input  logic                ARESETn,
  P2A_Push_FSM_Interface.FSM_P2A p2a,
  input  logic [ID_WIDTH-1:0] Cpl_ID,
  input  logic [1:0]          Cpl_Resp,
  input  logic                B_Full,
  output logic                B_Push,
  output b_entry_t            B_Entry,
  input  logic                R_Full,
  output logic                R_Push,
  output r_entry_t            R_Entry,
  output push_state_t         o_dbg_state
);

  localparam int MAX_BEATS = 1024 / DW_PER_BEAT;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);

  push_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_remain, w_remain_nxt;
  logic [ID_WIDTH-1:0] r_id, w_id_nxt;
  logic [1:0]          r_resp, w_resp_nxt;
  logic [CNT_W-1:0]    w_beats;
  logic                w_grant;
  logic                w_b_push;
  logic                w_r_push;
  b_entry_t            w_b_entry;
  r_entry_t            w_r_entry;

  assign w_beats = CNT_W'(cpl_beats(p2a.Cpl_Length, DW_PER_BEAT));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state  <= ST_IDLE;
      r_remain <= '0;
      r_id     <= '0;
      r_resp   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
      r_id     <= w_id_nxt;
      r_resp   <= w_resp_nxt;
    end
  end

  // Pushes are gated by ARESETn so nothing leaks out while reset is held
  // with a completion still presented upstream.
  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_id_nxt     = r_id;
    w_resp_nxt   = r_resp;
    w_grant      = 1'b0;
    w_b_push     = 1'b0;
    w_r_push     = 1'b0;
    w_b_entry    = '0;
    w_r_entry    = '0;
    if (ARESETn) begin
      case (r_state)
        ST_IDLE: begin
          case (p2a.Cpl_Type)
            CPL_WR: begin
              if (!B_Full) begin
                w_grant        = 1'b1;
                w_b_push       = 1'b1;
                w_b_entry.id   = Cpl_ID;
                w_b_entry.resp = Cpl_Resp;
              end
            end
            CPL_RD: begin
              if (!R_Full) begin
                w_grant        = 1'b1;
                w_r_push       = 1'b1;
                w_r_entry.data = p2a.Cpl_Data;
                w_r_entry.id   = Cpl_ID;
                w_r_entry.resp = Cpl_Resp;
                if (w_beats == CNT_W'(1)) begin
                  w_r_entry.last = 1'b1;
                end else begin
                  w_id_nxt     = Cpl_ID;
                  w_resp_nxt   = Cpl_Resp;
                  w_remain_nxt = w_beats - CNT_W'(1);
                  w_state_nxt  = ST_R_PUSH;
                end
              end
            end
            default: ;
          endcase
        end
        ST_R_PUSH: begin
          // Header and sideband are ignored here; the latched ID/resp tag every beat.
          if (!R_Full) begin
            w_grant        = 1'b1;
            w_r_push       = 1'b1;
            w_r_entry.data = p2a.Cpl_Data;
            w_r_entry.id   = r_id;
            w_r_entry.resp = r_resp;
            w_remain_nxt   = r_remain - CNT_W'(1);
            if (r_remain == CNT_W'(1)) begin
              w_r_entry.last = 1'b1;
              w_state_nxt    = ST_IDLE;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign p2a.Cpl_Grant   = w_grant;
  assign p2a.Cpl_Command = (r_state == ST_R_PUSH);
  assign B_Push          = w_b_push;
  assign B_Entry         = w_b_entry;
  assign R_Push          = w_r_push;
  assign R_Entry         = w_r_entry;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_axi_slave_push_fsm.sv
// Bench for axi_slave_push_fsm: directed scenarios plus random traffic,
// scored against expected B/R entry queues built from completion lengths.
module tb_axi_slave_push_fsm;
  import axi_slave_package::*;

  localparam int DW        = AXI_DATA_WIDTH;
  localparam int DW_BEAT   = DW / 32;
  localparam int MAX_BEATS = 1024 / DW_BEAT;
  localparam int R_W       = $bits(r_entry_t);
  localparam int B_W       = $bits(b_entry_t);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- DUT ----------------
  P2A_Push_FSM_Interface #(.DATA_WIDTH(DW)) p2a_if();
  logic [AXI_ID_WIDTH-1:0] cpl_id;
  logic [1:0]              cpl_resp;
  logic                    b_full, r_full;
  logic                    b_push, r_push;
  b_entry_t                b_entry;
  r_entry_t                r_entry;
  push_state_t             dbg_state;

  axi_slave_push_fsm dut (
    .ACLK        (clk),
    .ARESETn     (rst_n),
    .p2a         (p2a_if),
    .Cpl_ID      (cpl_id),
    .Cpl_Resp    (cpl_resp),
    .B_Full      (b_full),
    .B_Push      (b_push),
    .B_Entry     (b_entry),
    .R_Full      (r_full),
    .R_Push      (r_push),
    .R_Entry     (r_entry),
    .o_dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks;
  int n_fails;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [R_W-1:0] exp_r_q[$];
  logic [B_W-1:0] exp_b_q[$];
  int last_rlast_cyc;
  int last_b_cyc;

  always @(negedge clk) begin
    r_entry_t er;
    b_entry_t eb;
    if (r_push) begin
      if (exp_r_q.size() == 0) begin
        check_eq("r_unexpected", 256'(r_push), 256'(0));
      end else begin
        er = exp_r_q.pop_front();
        check_eq("r_hdr", 256'({r_entry.id, r_entry.resp, r_entry.last}),
                 256'({er.id, er.resp, er.last}));
        for (int s = 0; s < DW / 256; s++)
          check_eq("r_data", r_entry.data[s*256 +: 256], er.data[s*256 +: 256]);
        if (r_entry.last) last_rlast_cyc = cyc_cnt;
      end
    end
    if (b_push) begin
      if (exp_b_q.size() == 0) begin
        check_eq("b_unexpected", 256'(b_push), 256'(0));
      end else begin
        eb = exp_b_q.pop_front();
        check_eq("b_entry", 256'(b_entry), 256'(eb));
        last_b_cyc = cyc_cnt;
      end
    end
  end

  // ---------------- helpers / drivers ----------------
  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [1:0] rand_resp();
    return ($urandom_range(0, 1) == 1) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_eq(tag, 256'({p2a_if.Cpl_Grant, p2a_if.Cpl_Command, b_push, r_push, b_entry,
                        r_entry.id, r_entry.resp, r_entry.last, |r_entry.data}), 256'(0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      p2a_if.Cpl_Type   = CPL_NONE;
      p2a_if.Cpl_Length = 10'($urandom_range(0, 1023));
      p2a_if.Cpl_Data   = rand_data();
      cpl_id            = 4'($urandom_range(0, 15));
      cpl_resp          = rand_resp();
      b_full            = 1'($urandom_range(0, 1));
      r_full            = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("idle_grant", 256'(p2a_if.Cpl_Grant), 256'(0));
      check_eq("idle_cmd", 256'(p2a_if.Cpl_Command), 256'(0));
      check_eq("idle_state", 256'(dbg_state), 256'(ST_IDLE));
      @(posedge clk); #1;
    end
  endtask

  task automatic send_wr(input logic [3:0] id, input logic [1:0] resp, input int nfull);
    b_entry_t eb;
    eb.id   = id;
    eb.resp = resp;
    exp_b_q.push_back(eb);
    for (int i = 0; i <= nfull; i++) begin
      p2a_if.Cpl_Type   = CPL_WR;
      p2a_if.Cpl_Length = 10'($urandom_range(0, 1023));
      p2a_if.Cpl_Data   = rand_data();
      cpl_id            = id;
      cpl_resp          = resp;
      b_full            = (i < nfull);
      r_full            = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("wr_grant", 256'(p2a_if.Cpl_Grant), 256'(!b_full));
      check_eq("wr_bpush", 256'(b_push), 256'(!b_full));
      check_eq("wr_cmd", 256'(p2a_if.Cpl_Command), 256'(0));
      @(posedge clk); #1;
    end
    p2a_if.Cpl_Type = CPL_NONE;
    check_eq("wr_drained", 256'(exp_b_q.size()), 256'(0));
  endtask

  // mode 0: R FIFO never full; 1: full on alternate data-phase cycles; 2: random.
  // abort_after > 0 stops driving once that many beats were accepted.
  task automatic send_rd(input logic [9:0] len, input logic [3:0] id, input logic [1:0] resp,
                         input int mode, input int abort_after);
    logic [DW-1:0] data [MAX_BEATS];
    r_entry_t      er;
    int            beats, total_dw, k, cyc;
    logic          alt;
    total_dw = (len == 10'd0) ? 1024 : int'(len);
    beats    = (total_dw + DW_BEAT - 1) / DW_BEAT;
    for (int b = 0; b < beats; b++) begin
      data[b] = rand_data();
      er.data = data[b];
      er.id   = id;
      er.resp = resp;
      er.last = (b == beats - 1);
      exp_r_q.push_back(er);
    end
    k   = 0;
    cyc = 0;
    alt = 1'b1;
    while (k < beats && !(abort_after > 0 && k == abort_after)) begin
      p2a_if.Cpl_Data = data[k];
      if (k == 0) begin
        p2a_if.Cpl_Type   = CPL_RD;
        p2a_if.Cpl_Length = len;
        cpl_id            = id;
        cpl_resp          = resp;
        r_full            = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      end else begin
        p2a_if.Cpl_Type   = cpl_t'(2'($urandom_range(0, 2)));
        p2a_if.Cpl_Length = 10'($urandom_range(0, 1023));
        cpl_id            = 4'($urandom_range(0, 15));
        cpl_resp          = rand_resp();
        if (mode == 1) begin
          r_full = alt;
          alt    = !alt;
        end else if (mode == 2) begin
          r_full = (cyc < 100) && ($urandom_range(0, 3) == 0);
        end else begin
          r_full = 1'b0;
        end
      end
      b_full = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("rd_grant", 256'(p2a_if.Cpl_Grant), 256'(!r_full));
      check_eq("rd_rpush", 256'(r_push), 256'(!r_full));
      check_eq("rd_cmd", 256'(p2a_if.Cpl_Command), 256'(k > 0));
      if (!r_full) k++;
      @(posedge clk); #1;
      cyc++;
    end
    if (abort_after == 0) begin
      p2a_if.Cpl_Type = CPL_NONE;
      check_eq("rd_drained", 256'(exp_r_q.size()), 256'(0));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks          = 0;
    n_fails           = 0;
    cyc_cnt           = 0;
    last_rlast_cyc    = -10;
    last_b_cyc        = -10;
    rst_n             = 1'b0;
    p2a_if.Cpl_Type   = CPL_RD;
    p2a_if.Cpl_Length = 10'd64;
    p2a_if.Cpl_Data   = rand_data();
    cpl_id            = 4'h3;
    cpl_resp          = RESP_OKAY;
    b_full            = 1'b0;
    r_full            = 1'b0;

    // Reset held with a read presented: nothing may come out.
    repeat (2) begin
      @(negedge clk);
      check_outputs_zero("rst_outs");
      check_eq("rst_state", 256'(dbg_state), 256'(ST_IDLE));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_rd(10'd64, 4'h3, RESP_OKAY, 0, 0);
    idle(2);

    // Write response with B FIFO full for three cycles.
    send_wr(4'd5, RESP_SLVERR, 3);
    idle(1);

    // Maximal 1024-DW read, sideband toggling during the data phase.
    send_rd(10'd0, 4'hA, RESP_OKAY, 0, 0);
    idle(1);

    // 33 DW -> two beats, R FIFO full on alternate data-phase cycles.
    send_rd(10'd33, 4'h6, RESP_SLVERR, 1, 0);
    idle(1);

    // Reset after beat 3 of a 10-beat read.
    send_rd(10'd320, 4'h9, RESP_OKAY, 0, 3);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_async");
    exp_r_q.delete();
    @(negedge clk);
    check_outputs_zero("rst_mid_outs");
    check_eq("rst_mid_state", 256'(dbg_state), 256'(ST_IDLE));
    @(posedge clk); #1;
    rst_n           = 1'b1;
    p2a_if.Cpl_Type = CPL_NONE;
    idle(2);
    send_wr(4'hC, RESP_OKAY, 0);
    idle(1);

    // Single-beat read immediately followed by a write.
    send_rd(10'd1, 4'h2, RESP_OKAY, 0, 0);
    send_wr(4'h7, RESP_SLVERR, 0);
    check_eq("b2b_gap", 256'(last_b_cyc - last_rlast_cyc), 256'(1));
    idle(1);

    // Random traffic.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 2) == 0)
        send_wr(4'($urandom_range(0, 15)), rand_resp(), $urandom_range(0, 3));
      else
        send_rd(10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), rand_resp(), 2, 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    check_eq("final_r_q", 256'(exp_r_q.size()), 256'(0));
    check_eq("final_b_q", 256'(exp_b_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
